// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the vector CPU pipeline control logic.
package cpu_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_sel.sv
// E-stage operand bypass select; the M result wins over the W result.
module forward_sel
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] ra_e_i,
  input  logic [REG_AW-1:0] wa3_m_i,
  input  logic              regwrite_m_i,
  input  logic [REG_AW-1:0] wa3_w_i,
  input  logic              regwrite_w_i,
  output logic [1:0]        fwd_o
);

  // Priority bypass select for one operand
  always_comb begin
    fwd_o = FWD_RF;
    if (regwrite_m_i && (wa3_m_i == ra_e_i)) begin
      fwd_o = FWD_MEM;
    end else if (regwrite_w_i && (wa3_w_i == ra_e_i)) begin
      fwd_o = FWD_WB;
    end else begin
      fwd_o = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage vector CPU: load-use stalls, memory
// wait freeze with watchdog, operand forwarding and a stall-cycle counter.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_AW-1:0]      ra1_d,
  input  logic [REG_AW-1:0]      ra2_d,
  input  logic                   uses_rb_d,
  input  logic [REG_AW-1:0]      ra1_e,
  input  logic [REG_AW-1:0]      ra2_e,
  input  logic [REG_AW-1:0]      wa3_e,
  input  logic                   regwrite_e,
  input  logic                   memtoreg_e,
  input  logic [REG_AW-1:0]      wa3_m,
  input  logic                   regwrite_m,
  input  logic                   memtoreg_m,
  input  logic                   memwrite_m,
  input  logic [REG_AW-1:0]      wa3_w,
  input  logic                   regwrite_w,
  input  logic                   mem_ack,
  output logic                   pc_en,
  output logic                   cargar_fd,
  output logic                   cargar_de,
  output logic                   cargar_em,
  output logic                   cargar_mw,
  output logic                   flush_de,
  output logic                   mem_req,
  output logic [1:0]             fwd_a_e,
  output logic [1:0]             fwd_b_e,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int                      WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]       WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [STALL_CNT_W-1:0]  CNT_MAX   = '1;

  ctrl_state_t            state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   mem_err_q, mem_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       memop_s, timeout_s, memstall_s, lduse_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  assign memop_s    = memtoreg_m | memwrite_m;
  assign timeout_s  = (state_q == MEM_WAIT) && (wait_q == WAIT_LAST) && !mem_ack;
  assign memstall_s = memop_s & ~mem_ack & ~timeout_s;
  assign lduse_s    = regwrite_e & memtoreg_e &
                      ((wa3_e == ra1_d) | (uses_rb_d & (wa3_e == ra2_d)));

  forward_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ra_e_i       (ra1_e),
    .wa3_m_i      (wa3_m),
    .regwrite_m_i (regwrite_m),
    .wa3_w_i      (wa3_w),
    .regwrite_w_i (regwrite_w),
    .fwd_o        (fwd_a_s)
  );

  forward_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ra_e_i       (ra2_e),
    .wa3_m_i      (wa3_m),
    .regwrite_m_i (regwrite_m),
    .wa3_w_i      (wa3_w),
    .regwrite_w_i (regwrite_w),
    .fwd_o        (fwd_b_s)
  );

  // Pipe enables: reset holds a bubble in D/E, then memstall > lduse > run
  always_comb begin
    pc_en     = 1'b0;
    cargar_fd = 1'b0;
    cargar_de = 1'b0;
    cargar_em = 1'b0;
    cargar_mw = 1'b0;
    flush_de  = 1'b1;
    if (!reset) begin
      flush_de  = 1'b1;
    end else if (memstall_s) begin
      flush_de  = 1'b0;
    end else if (lduse_s) begin
      cargar_de = 1'b1;
      cargar_em = 1'b1;
      cargar_mw = 1'b1;
      flush_de  = 1'b1;
    end else begin
      pc_en     = 1'b1;
      cargar_fd = 1'b1;
      cargar_de = 1'b1;
      cargar_em = 1'b1;
      cargar_mw = 1'b1;
      flush_de  = 1'b0;
    end
  end

  // Gating by reset makes mem_req and the bypass selects drop asynchronously
  assign mem_req   = reset & memop_s;
  assign fwd_a_e   = reset ? fwd_a_s : FWD_RF;
  assign fwd_b_e   = reset ? fwd_b_s : FWD_RF;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

  // Next state for the wait FSM, watchdog flag and stall counter
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_err_d   = mem_err_q | timeout_s;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        wait_d = '0;
        if (memop_s && !mem_ack) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        if (mem_ack || (wait_q == WAIT_LAST)) begin
          state_d = RUN;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
    if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, wait counter, sticky error and performance counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic [3:0] ra1_d, ra2_d;
    logic       uses_rb_d;
    logic [3:0] ra1_e, ra2_e, wa3_e;
    logic       regwrite_e, memtoreg_e;
    logic [3:0] wa3_m;
    logic       regwrite_m, memtoreg_m, memwrite_m;
    logic [3:0] wa3_w;
    logic       regwrite_w, mem_ack;
  } in_t;

  typedef struct {
    string       nm;
    logic [6:0]  ctrl;
    logic [1:0]  fa, fb;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  // {pc_en, cargar_fd, cargar_de, cargar_em, cargar_mw, flush_de, mem_req}
  localparam logic [6:0] RSTV = 7'b0000010;
  localparam logic [6:0] RUNV = 7'b1111100;
  localparam logic [6:0] LDU  = 7'b0011110;
  localparam logic [6:0] FRZ  = 7'b0000001;
  localparam logic [6:0] ADVQ = 7'b1111101;

  logic        clk, reset;
  logic [3:0]  ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic        uses_rb_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m;
  logic        memwrite_m, regwrite_w, mem_ack;
  logic        pc_en, cargar_fd, cargar_de, cargar_em, cargar_mw, flush_de, mem_req;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        mem_err;
  logic [15:0] stall_cnt;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        prev_rst = 1'b0;
  logic        prev_pc = 1'b0;

  pipe_hazard_ctrl #(.REG_AW(4), .MEM_TIMEOUT(8), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .uses_rb_d(uses_rb_d),
    .ra1_e(ra1_e), .ra2_e(ra2_e),
    .wa3_e(wa3_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .wa3_m(wa3_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
    .wa3_w(wa3_w), .regwrite_w(regwrite_w), .mem_ack(mem_ack),
    .pc_en(pc_en), .cargar_fd(cargar_fd), .cargar_de(cargar_de),
    .cargar_em(cargar_em), .cargar_mw(cargar_mw), .flush_de(flush_de),
    .mem_req(mem_req), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic in_t idle();
    in_t v;
    v.ra1_d = 4'd1; v.ra2_d = 4'd2; v.uses_rb_d = 1'b1;
    v.ra1_e = 4'd0; v.ra2_e = 4'd0; v.wa3_e = 4'd0;
    v.regwrite_e = 1'b0; v.memtoreg_e = 1'b0;
    v.wa3_m = 4'd0; v.regwrite_m = 1'b0; v.memtoreg_m = 1'b0; v.memwrite_m = 1'b0;
    v.wa3_w = 4'd0; v.regwrite_w = 1'b0; v.mem_ack = 1'b0;
    return v;
  endfunction

  task automatic drive(input logic rst, input in_t v);
    reset = rst;
    ra1_d = v.ra1_d; ra2_d = v.ra2_d; uses_rb_d = v.uses_rb_d;
    ra1_e = v.ra1_e; ra2_e = v.ra2_e; wa3_e = v.wa3_e;
    regwrite_e = v.regwrite_e; memtoreg_e = v.memtoreg_e;
    wa3_m = v.wa3_m; regwrite_m = v.regwrite_m;
    memtoreg_m = v.memtoreg_m; memwrite_m = v.memwrite_m;
    wa3_w = v.wa3_w; regwrite_w = v.regwrite_w; mem_ack = v.mem_ack;
  endtask

  // One cycle of stimulus; the counter expectation follows the expected pc_en
  task automatic step(input string nm, input logic rst, input in_t v,
                      input logic [6:0] ctrl, input logic [1:0] fa, input logic [1:0] fb,
                      input logic err);
    exp_t e;
    @(posedge clk);
    if (prev_rst && !prev_pc && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
    drive(rst, v);
    if (!rst) exp_cnt = 16'd0;
    e.nm = nm; e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.err = err; e.cnt = exp_cnt;
    sb.push_back(e);
    prev_rst = rst;
    prev_pc  = ctrl[6];
  endtask

  task automatic chk(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "ctrl", {9'd0, pc_en, cargar_fd, cargar_de, cargar_em, cargar_mw,
                           flush_de, mem_req}, {9'd0, e.ctrl});
        chk(e.nm, "fwd", {12'd0, fwd_a_e, fwd_b_e}, {12'd0, e.fa, e.fb});
        chk(e.nm, "mem_err", {15'd0, mem_err}, {15'd0, e.err});
        chk(e.nm, "stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    in_t v;
    v = idle();
    v.memtoreg_m = 1'b1;
    drive(1'b0, v);

    // Reset with a pending memory op and a forwarding match present
    v.ra1_e = 4'd3; v.wa3_m = 4'd3; v.regwrite_m = 1'b1;
    for (int i = 0; i < 3; i++) step("reset", 1'b0, v, RSTV, 2'b00, 2'b00, 1'b0);
    step("release", 1'b1, idle(), RUNV, 2'b00, 2'b00, 1'b0);

    // Memory wait: ack on the 4th cycle
    v = idle(); v.memwrite_m = 1'b1;
    for (int i = 0; i < 3; i++) step("memwait", 1'b1, v, FRZ, 2'b00, 2'b00, 1'b0);
    v.mem_ack = 1'b1;
    step("memack", 1'b1, v, ADVQ, 2'b00, 2'b00, 1'b0);
    step("after_mem", 1'b1, idle(), RUNV, 2'b00, 2'b00, 1'b0);

    // Load-use on ra2, then without uses_rb_d, then on ra1
    v = idle(); v.memtoreg_e = 1'b1; v.regwrite_e = 1'b1; v.wa3_e = 4'd5; v.ra2_d = 4'd5;
    step("lduse_rb", 1'b1, v, LDU, 2'b00, 2'b00, 1'b0);
    step("lduse_clear", 1'b1, idle(), RUNV, 2'b00, 2'b00, 1'b0);
    v.uses_rb_d = 1'b0;
    step("no_rb", 1'b1, v, RUNV, 2'b00, 2'b00, 1'b0);
    v.ra1_d = 4'd5;
    step("lduse_ra", 1'b1, v, LDU, 2'b00, 2'b00, 1'b0);

    // Back-to-back memory ops each get their own wait
    v = idle(); v.memtoreg_m = 1'b1;
    step("b2b_w1", 1'b1, v, FRZ, 2'b00, 2'b00, 1'b0);
    v.mem_ack = 1'b1;
    step("b2b_a1", 1'b1, v, ADVQ, 2'b00, 2'b00, 1'b0);
    v.mem_ack = 1'b0;
    step("b2b_w2", 1'b1, v, FRZ, 2'b00, 2'b00, 1'b0);
    v.mem_ack = 1'b1;
    step("b2b_a2", 1'b1, v, ADVQ, 2'b00, 2'b00, 1'b0);

    // Forwarding
    v = idle(); v.ra1_e = 4'd3; v.wa3_m = 4'd3; v.regwrite_m = 1'b1;
    v.wa3_w = 4'd3; v.regwrite_w = 1'b1; v.ra2_e = 4'd9;
    step("fwd_m_pri", 1'b1, v, RUNV, 2'b10, 2'b00, 1'b0);
    v.regwrite_m = 1'b0;
    step("fwd_w", 1'b1, v, RUNV, 2'b01, 2'b00, 1'b0);
    v.ra2_e = 4'd3;
    step("fwd_b_w", 1'b1, v, RUNV, 2'b01, 2'b01, 1'b0);
    v.regwrite_m = 1'b1;
    step("fwd_b_m", 1'b1, v, RUNV, 2'b10, 2'b10, 1'b0);

    // Watchdog: no ack, forced advance on the 9th cycle
    v = idle(); v.memtoreg_m = 1'b1;
    for (int i = 0; i < 8; i++) step("wd_wait", 1'b1, v, FRZ, 2'b00, 2'b00, 1'b0);
    step("wd_force", 1'b1, v, ADVQ, 2'b00, 2'b00, 1'b0);
    step("wd_err", 1'b1, idle(), RUNV, 2'b00, 2'b00, 1'b1);
    step("wd_sticky", 1'b1, idle(), RUNV, 2'b00, 2'b00, 1'b1);

    // memstall beats lduse; then reset lands mid-wait
    v = idle(); v.memtoreg_m = 1'b1;
    v.memtoreg_e = 1'b1; v.regwrite_e = 1'b1; v.wa3_e = 4'd5; v.ra1_d = 4'd5;
    step("prio", 1'b1, v, FRZ, 2'b00, 2'b00, 1'b1);
    step("prio_wait", 1'b1, v, FRZ, 2'b00, 2'b00, 1'b1);
    step("rst_midwait", 1'b0, v, RSTV, 2'b00, 2'b00, 1'b0);
    step("rst_release", 1'b1, idle(), RUNV, 2'b00, 2'b00, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage vector CPU (F, D, E, M, W).
- Drives the load enables (`cargar`) and the bubble flush of the F/D, D/E, E/M and M/W pipe registers.
- Detects load-use hazards, generates the E-stage operand forwarding selects, and stalls the pipe while the vector memory serves an M-stage access.
- A watchdog aborts a stuck memory access. A saturating counter counts stall cycles.

Parameters:
- REG_AW, 4, register address width (16 vector registers).
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before a forced advance (>=2).
- STALL_CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ra1_d, ra2_d  in  REG_AW  D-stage source register addresses.
- uses_rb_d  in  1  D-stage instruction reads ra2.
- ra1_e, ra2_e  in  REG_AW  E-stage source addresses (D/E pipe outputs).
- wa3_e, regwrite_e, memtoreg_e  in  REG_AW,1,1  E-stage destination and controls.
- wa3_m, regwrite_m, memtoreg_m, memwrite_m  in  REG_AW,1,1,1  M-stage destination and controls.
- wa3_w, regwrite_w  in  REG_AW,1  W-stage destination and write enable.
- mem_ack  in  1  vector memory completes the current M-stage access this cycle.
- pc_en  out  1  PC register load enable.
- cargar_fd, cargar_de, cargar_em, cargar_mw  out  1 each  pipe register load enables.
- flush_de  out  1  drives the synchronous reset of the D/E pipe (inserts a bubble).
- mem_req  out  1  M-stage memory access request.
- fwd_a_e, fwd_b_e  out  2  E-stage operand select: 00 register file, 01 W result, 10 M result.
- mem_err  out  1  sticky: a watchdog timeout has occurred.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- While reset=0:
  - State RUN; wait counter 0; mem_err 0; stall_cnt 0.
  - All enables 0, flush_de=1, mem_req=0, fwd_*=00.
  - Reset asserted mid-MEM_WAIT drops mem_req immediately (asynchronous).
- memop_m = memtoreg_m | memwrite_m. mem_req = memop_m in both states.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when memop_m & !mem_ack.
  - MEM_WAIT -> RUN when mem_ack, or when the wait counter reaches MEM_TIMEOUT-1.
  - The wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
- timeout = (state==MEM_WAIT) & (wait counter==MEM_TIMEOUT-1) & !mem_ack. On timeout, mem_err is set and held until reset.
- memstall = memop_m & !mem_ack & !timeout.
- lduse = regwrite_e & memtoreg_e & ((wa3_e==ra1_d) | (uses_rb_d & (wa3_e==ra2_d))).
- Output priority (combinational, same cycle as inputs):
  - If memstall: all enables 0 and flush_de=0; the whole pipe freezes.
  - Else if lduse: pc_en=0, cargar_fd=0, flush_de=1, cargar_de=1, cargar_em=1, cargar_mw=1. Exactly one bubble is inserted; the hazard clears the next cycle once the load moves to M.
  - Else: all enables 1, flush_de=0.
- An ack cycle (mem_ack=1) advances the pipe in the same cycle; no extra dead cycle.
- Forwarding for operand A (B identical with ra2_e):
  - 10 if regwrite_m & (wa3_m==ra1_e);
  - else 01 if regwrite_w & (wa3_w==ra1_e);
  - else 00.
  - M has priority over W when both match.
- stall_cnt increments on every clock where pc_en=0 and reset=1. It saturates at all-ones.
- Back-to-back memory ops in M each get their own MEM_WAIT; state returns to RUN between them for at least the advancing cycle.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - enum ctrl_state_t {RUN, MEM_WAIT};
  - constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, forward_sel (pure combinational, REG_AW parameter), instantiated twice for operands A and B.
- The FSM, watchdog, stall logic and counter live in pipe_hazard_ctrl.

Test Plan:
- Reset low for 3 cycles while mem_ack=0 and memtoreg_m=1 -> enables 0, flush_de=1, mem_req=0. After release with no hazards -> all enables 1, stall_cnt=0.
- Load-use:
  - Stimulus: E holds memtoreg_e=1, regwrite_e=1, wa3_e=5; D holds ra2_d=5, uses_rb_d=1.
  - Response: one cycle with pc_en=0, cargar_fd=0, flush_de=1.
  - The same case with uses_rb_d=0 -> no stall.
- Memory wait: memwrite_m=1, mem_ack raised on the 4th cycle -> 3 cycles of all enables 0 with mem_req=1, advance in the ack cycle, stall_cnt=3.
- Watchdog: MEM_TIMEOUT=8, memtoreg_m=1, mem_ack never -> forced advance on the 9th cycle (counter=7 in MEM_WAIT). mem_err=1 and remains set until reset.
- Forwarding: ra1_e=3, wa3_m=3, regwrite_m=1, wa3_w=3, regwrite_w=1 -> fwd_a_e=10. Clearing regwrite_m -> fwd_a_e=01. ra2_e=9 with no match -> fwd_b_e=00.
- Priority and reset mid-wait: memstall and lduse simultaneously -> all enables 0, flush_de=0. Reset asserted mid-MEM_WAIT -> state RUN, mem_req=0, mem_err=0 asynchronously.
